// File: rtl/matrix_load_sequencer.sv
// Sequences one matrix-multiply job: loads A and B from the UART byte stream, starts the
// multiplier, then streams the result memory out. Optional load watchdog: LOAD_TIMEOUT_EN.
module matrix_load_sequencer #(
  parameter int unsigned ROWS    = 2,
  parameter int unsigned COLS    = 2,
  parameter int unsigned AW      = 6,
  parameter int unsigned RW      = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          mem_we,
  output logic          mem_sel,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic          mul_start,
  input  logic          mul_done,
  output logic          res_re,
  output logic [AW-1:0] res_raddr,
  input  logic [RW-1:0] res_data,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          ovr,
  output logic          err
);

  localparam int unsigned N = ROWS * COLS;
  localparam int unsigned R = ROWS * ROWS;
  localparam logic [AW-1:0] NLast = AW'(N - 1);
  localparam logic [AW-1:0] RLast = AW'(R - 1);

  typedef enum logic [2:0] {
    StLoadA, StLoadB, StStart, StWait, StRd, StCap, StOut, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic          mem_we_d, mem_sel_d, mul_start_d, res_re_d, out_valid_d, busy_d, ovr_d;
  logic [AW-1:0] mem_waddr_d, res_raddr_d;
  logic [7:0]    mem_wdata_d;
  logic [RW-1:0] out_data_d;

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned GW = $clog2(TIMEOUT + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic          err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel;
    mem_waddr_d = mem_waddr;
    mem_wdata_d = mem_wdata;
    mul_start_d = 1'b0;
    res_re_d    = 1'b0;
    res_raddr_d = res_raddr;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    ovr_d       = ovr;

    case (state_q)
      StLoadA, StLoadB: begin
        if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = (state_q == StLoadB);
          mem_waddr_d = cnt_q;
          mem_wdata_d = rx_byte;
          if (cnt_q == NLast) begin
            cnt_d   = '0;
            state_d = (state_q == StLoadA) ? StLoadB : StStart;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        mul_start_d = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        // Read enable is issued on entry to RD so data is ready for CAP.
        if (mul_done) begin
          idx_d       = '0;
          res_re_d    = 1'b1;
          res_raddr_d = '0;
          state_d     = StRd;
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        out_data_d  = res_data;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready && out_valid) begin
          out_valid_d = 1'b0;
          if (idx_q == RLast) begin
            state_d = StDone;
          end else begin
            idx_d       = idx_q + 1'b1;
            res_re_d    = 1'b1;
            res_raddr_d = idx_q + 1'b1;
            state_d     = StRd;
          end
        end
      end
      StDone: begin
        if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = 1'b0;
          mem_waddr_d = '0;
          mem_wdata_d = rx_byte;
          if (N == 1) begin
            cnt_d   = '0;
            state_d = StLoadB;
          end else begin
            cnt_d   = AW'(1);
            state_d = StLoadA;
          end
        end
      end
      default: state_d = StLoadA;
    endcase

    if (rx_valid && state_q inside {StStart, StWait, StRd, StCap, StOut}) ovr_d = 1'b1;

`ifdef LOAD_TIMEOUT_EN
    gap_d = '0;
    err_d = err;
    if ((state_q == StLoadA && cnt_q != '0) || state_q == StLoadB) begin
      if (rx_valid) begin
        gap_d = '0;
      end else if (gap_q == GW'(TIMEOUT - 1)) begin
        state_d = StLoadA;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
    if (rx_valid && state_q == StLoadA) err_d = 1'b0;
`endif

    busy_d = !((state_d == StLoadA && cnt_d == '0) || state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StLoadA;
      cnt_q     <= '0;
      idx_q     <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mul_start <= 1'b0;
      res_re    <= 1'b0;
      res_raddr <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mem_we    <= mem_we_d;
      mem_sel   <= mem_sel_d;
      mem_waddr <= mem_waddr_d;
      mem_wdata <= mem_wdata_d;
      mul_start <= mul_start_d;
      res_re    <= res_re_d;
      res_raddr <= res_raddr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
      ovr       <= ovr_d;
    end
  end

`ifdef LOAD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= '0;
      err   <= 1'b0;
    end else begin
      gap_q <= gap_d;
      err   <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer: write and output scoreboards fed by the
// stimulus, checked by a negedge monitor.
module tb_matrix_load_sequencer;
  localparam int unsigned AW = 6;
  localparam int unsigned RW = 16;
`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned TO = 50;
`else
  localparam int unsigned TO = 100000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid, mul_done, out_ready;
  logic [7:0]    rx_byte;
  logic          mem_we, mem_sel, mul_start, res_re, out_valid, busy, ovr, err;
  logic [AW-1:0] mem_waddr, res_raddr;
  logic [7:0]    mem_wdata;
  logic [RW-1:0] res_data, out_data;

  matrix_load_sequencer #(
    .ROWS(2), .COLS(2), .AW(AW), .RW(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mul_start(mul_start), .mul_done(mul_done), .res_re(res_re), .res_raddr(res_raddr),
    .res_data(res_data), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .ovr(ovr), .err(err)
  );

  always #5 clk = ~clk;

  // Result memory model: registered read, contents addr + 100.
  always @(posedge clk) if (res_re) res_data <= RW'(res_raddr) + RW'(100);

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           wr_q[$];
  logic [RW-1:0] out_q[$];
  int checks = 0, errors = 0;
  int n_wr = 0, n_xfer = 0, n_start = 0, ld_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      n_wr++;
      check("write_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        wr_t e;
        e = wr_q.pop_front();
        check("mem_write", {mem_sel, mem_waddr, mem_wdata}, {e.sel, e.addr, e.data});
      end
    end
    if (out_valid && out_ready) begin
      n_xfer++;
      check("xfer_expected", out_q.size() != 0, 1);
      if (out_q.size() != 0) check("out_data", out_data, out_q.pop_front());
    end
    if (mul_start) n_start++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    wr_t e;
    e.sel  = (ld_cnt >= 4);
    e.addr = AW'(ld_cnt % 4);
    e.data = b;
    wr_q.push_back(e);
    ld_cnt   = (ld_cnt + 1) % 8;
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic load_job(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      send(base + 8'(i));
      tick(19);
    end
  endtask

  task automatic wait_start(input int prev);
    int n = 0;
    while (n_start == prev && n < 200) begin
      tick();
      n++;
    end
    check("mul_start_count", n_start, prev + 1);
  endtask

  task automatic finish_job(input int delay);
    for (int i = 0; i < 4; i++) out_q.push_back(RW'(100 + i));
    tick(delay);
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
  endtask

  task automatic wait_outputs(input string tag);
    int n = 0;
    while (out_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check(tag, out_q.size(), 0);
    tick(2);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  task automatic check_idle();
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_mem_waddr", mem_waddr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_res_re", res_re, 0);
    check("rst_res_raddr", res_raddr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", ovr, 0);
    check("rst_err", err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, xf0, st0;
    logic stable;
    rst = 1'b0; rx_valid = 1'b0; rx_byte = '0; mul_done = 1'b0; out_ready = 1'b0;
    tick(3);
    check_idle();
    rst = 1'b1;
    tick(2);
    check("idle_busy", busy, 0);

    // 1 + 2: basic load, multiplier start, streamed results.
    out_ready = 1'b1;
    wr0 = n_wr; st0 = n_start;
    send(8'h01);
    check("busy_after_first_byte", busy, 1);
    tick(19);
    for (int i = 1; i < 8; i++) begin
      send(8'h01 + 8'(i));
      tick(19);
    end
    check("job1_writes", n_wr - wr0, 8);
    wait_start(st0);
    finish_job(10);
    wait_outputs("job1_outputs");
    check("job1_done_busy", busy, 0);
    check("job1_single_start", n_start, st0 + 1);
    check("job1_ovr", ovr, 0);

    // 3: backpressure on element 1.
    out_ready = 1'b0;
    st0 = n_start;
    load_job(8'h20);
    wait_start(st0);
    finish_job(10);
    wait_valid("elem0_valid");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("elem1_valid");
    xf0 = n_xfer;
    stable = 1'b1;
    repeat (50) begin
      if (out_valid !== 1'b1 || out_data !== RW'(101)) stable = 1'b0;
      tick();
    end
    check("stall_stable", stable, 1);
    check("stall_no_xfer", n_xfer, xf0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(2);
    check("stall_one_xfer", n_xfer, xf0 + 1);
    out_ready = 1'b1;
    wait_outputs("job2_outputs");
    check("job2_done_busy", busy, 0);

    // 4: byte arriving during WAIT is dropped and flagged.
    wr0 = n_wr; st0 = n_start;
    load_job(8'h40);
    wait_start(st0);
    rx_valid = 1'b1;
    rx_byte  = 8'hAA;
    tick();
    rx_valid = 1'b0;
    tick(2);
    check("wait_ovr", ovr, 1);
    finish_job(5);
    wait_outputs("job3_outputs");
    check("job3_writes", n_wr - wr0, 8);
    check("ovr_sticky", ovr, 1);

    // 5: reset mid-load, then a clean reload from A[0].
    for (int i = 0; i < 5; i++) begin
      send(8'h60 + 8'(i));
      tick(19);
    end
    check("partial_writes_seen", wr_q.size(), 0);
    rst = 1'b0;
    tick(2);
    check_idle();
    rst = 1'b1;
    ld_cnt = 0;
    tick(2);
    st0 = n_start;
    load_job(8'h80);
    wait_start(st0);
    finish_job(10);
    wait_outputs("job4_outputs");
    check("job4_done_busy", busy, 0);

`ifdef LOAD_TIMEOUT_EN
    // 6: inter-byte gap expiry returns to LOAD_A with err set.
    for (int i = 0; i < 3; i++) begin
      send(8'hC0 + 8'(i));
      tick(4);
    end
    tick(60);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    ld_cnt = 0;
    send(8'h11);
    tick(2);
    check("timeout_err_cleared", err, 0);
`endif

    tick(5);
    check("write_queue_drained", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
